// File: rtl/cpu_sram_axi_bridge_if.sv
// AXI read/write channels between the SRAM-to-AXI bridge and the SoC interconnect.
// Constant AXI fields (len, burst, wlast, awid, lock/cache/prot) are tied off at integration.
interface cpu_sram_axi_bridge_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic [3:0]          arid;
  logic [ADDR_W-1:0]   araddr;
  logic [2:0]          arsize;
  logic                arvalid;
  logic                arready;
  logic [3:0]          rid;
  logic [DATA_W-1:0]   rdata;
  logic                rvalid;
  logic                rready;
  logic [ADDR_W-1:0]   awaddr;
  logic [2:0]          awsize;
  logic                awvalid;
  logic                awready;
  logic [DATA_W-1:0]   wdata;
  logic [DATA_W/8-1:0] wstrb;
  logic                wvalid;
  logic                wready;
  logic                bvalid;
  logic                bready;

  modport master (
    output arid, araddr, arsize, arvalid, input arready,
    input rid, rdata, rvalid, output rready,
    output awaddr, awsize, awvalid, input awready,
    output wdata, wstrb, wvalid, input wready,
    input bvalid, output bready
  );

  modport slave (
    input arid, araddr, arsize, arvalid, output arready,
    output rid, rdata, rvalid, input rready,
    input awaddr, awsize, awvalid, output awready,
    input wdata, wstrb, wvalid, output wready,
    output bvalid, input bready
  );
endinterface

// File: rtl/cpu_sram_axi_bridge.sv
// Merges the core's instruction and data SRAM-like ports onto one AXI master port.
// One read and one write in flight at most; the data port wins arbitration.
module cpu_sram_axi_bridge #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                inst_req,
  input  logic [1:0]          inst_size,
  input  logic [ADDR_W-1:0]   inst_addr,
  output logic                inst_addr_ok,
  output logic                inst_data_ok,
  output logic [DATA_W-1:0]   inst_rdata,
  input  logic                data_req,
  input  logic                data_wr,
  input  logic [1:0]          data_size,
  input  logic [ADDR_W-1:0]   data_addr,
  input  logic [DATA_W/8-1:0] data_wstrb,
  input  logic [DATA_W-1:0]   data_wdata,
  output logic                data_addr_ok,
  output logic                data_data_ok,
  output logic [DATA_W-1:0]   data_rdata,
  cpu_sram_axi_bridge_if.master axi
);

  typedef enum logic [1:0] {R_IDLE, R_AR, R_R} r_state_t;
  typedef enum logic [1:0] {W_IDLE, W_AW, W_B} w_state_t;

  r_state_t            r_state;
  w_state_t            w_state;
  logic                r_owner;
  logic [ADDR_W-1:0]   ar_addr;
  logic [1:0]          ar_size;
  logic                arvalid_q;
  logic                rready_q;
  logic                data_rd_ok;
  logic [ADDR_W-1:0]   aw_addr;
  logic [1:0]          aw_size;
  logic [DATA_W-1:0]   w_data;
  logic [DATA_W/8-1:0] w_strb;
  logic                awvalid_q;
  logic                wvalid_q;
  logic                bready_q;
  logic                data_wr_ok;
  logic                r_idle;
  logic                w_idle;
  logic                data_rd_go;
  logic                data_wr_go;
  logic                unused_rid;

  assign r_idle = (r_state == R_IDLE);
  assign w_idle = (w_state == W_IDLE);

  // A load waits for both FSMs to be idle so it can never pass an earlier store.
  assign data_addr_ok = data_req & w_idle & (r_idle | ~r_owner) & (data_wr | r_idle);
  assign inst_addr_ok = inst_req & r_idle & ~(data_req & ~data_wr & w_idle);
  assign data_rd_go   = data_addr_ok & ~data_wr;
  assign data_wr_go   = data_addr_ok & data_wr;

  assign axi.arid    = {3'b000, r_owner};
  assign axi.araddr  = ar_addr;
  assign axi.arsize  = {1'b0, ar_size};
  assign axi.arvalid = arvalid_q;
  assign axi.rready  = rready_q;
  assign axi.awaddr  = aw_addr;
  assign axi.awsize  = {1'b0, aw_size};
  assign axi.awvalid = awvalid_q;
  assign axi.wdata   = w_data;
  assign axi.wstrb   = w_strb;
  assign axi.wvalid  = wvalid_q;
  assign axi.bready  = bready_q;

  assign data_data_ok = data_rd_ok | data_wr_ok;
  assign unused_rid   = ^axi.rid;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= R_IDLE;
      r_owner      <= 1'b0;
      ar_addr      <= '0;
      ar_size      <= '0;
      arvalid_q    <= 1'b0;
      rready_q     <= 1'b0;
      inst_rdata   <= '0;
      data_rdata   <= '0;
      inst_data_ok <= 1'b0;
      data_rd_ok   <= 1'b0;
    end else begin
      inst_data_ok <= 1'b0;
      data_rd_ok   <= 1'b0;
      case (r_state)
        R_IDLE: begin
          if (data_rd_go) begin
            r_owner   <= 1'b1;
            ar_addr   <= data_addr;
            ar_size   <= data_size;
            arvalid_q <= 1'b1;
            r_state   <= R_AR;
          end else if (inst_addr_ok) begin
            r_owner   <= 1'b0;
            ar_addr   <= inst_addr;
            ar_size   <= inst_size;
            arvalid_q <= 1'b1;
            r_state   <= R_AR;
          end
        end
        R_AR: begin
          if (axi.arready) begin
            arvalid_q <= 1'b0;
            rready_q  <= 1'b1;
            r_state   <= R_R;
          end
        end
        R_R: begin
          if (axi.rvalid) begin
            rready_q <= 1'b0;
            r_state  <= R_IDLE;
            if (r_owner) begin
              data_rdata <= axi.rdata;
              data_rd_ok <= 1'b1;
            end else begin
              inst_rdata   <= axi.rdata;
              inst_data_ok <= 1'b1;
            end
          end
        end
        default: r_state <= R_IDLE;
      endcase
    end
  end

  // AW and W complete independently; B is only accepted once both are done.
  always_ff @(posedge clk) begin
    if (rst) begin
      w_state    <= W_IDLE;
      aw_addr    <= '0;
      aw_size    <= '0;
      w_data     <= '0;
      w_strb     <= '0;
      awvalid_q  <= 1'b0;
      wvalid_q   <= 1'b0;
      bready_q   <= 1'b0;
      data_wr_ok <= 1'b0;
    end else begin
      data_wr_ok <= 1'b0;
      case (w_state)
        W_IDLE: begin
          if (data_wr_go) begin
            aw_addr   <= data_addr;
            aw_size   <= data_size;
            w_data    <= data_wdata;
            w_strb    <= data_wstrb;
            awvalid_q <= 1'b1;
            wvalid_q  <= 1'b1;
            w_state   <= W_AW;
          end
        end
        W_AW: begin
          if (awvalid_q && axi.awready) awvalid_q <= 1'b0;
          if (wvalid_q && axi.wready) wvalid_q <= 1'b0;
          if ((!awvalid_q || axi.awready) && (!wvalid_q || axi.wready)) begin
            bready_q <= 1'b1;
            w_state  <= W_B;
          end
        end
        W_B: begin
          if (axi.bvalid) begin
            bready_q   <= 1'b0;
            data_wr_ok <= 1'b1;
            w_state    <= W_IDLE;
          end
        end
        default: w_state <= W_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_cpu_sram_axi_bridge.sv
// Directed bench for cpu_sram_axi_bridge: a CPU-side driver, a delay-configurable AXI
// slave with a byte-strobed memory, and a per-port scoreboard of expected responses.
module tb_cpu_sram_axi_bridge;

  typedef struct {
    bit          wr;
    logic [31:0] data;
  } exp_t;

  logic        clk;
  logic        rst;
  logic        inst_req;
  logic [1:0]  inst_size;
  logic [31:0] inst_addr;
  logic        inst_addr_ok;
  logic        inst_data_ok;
  logic [31:0] inst_rdata;
  logic        data_req;
  logic        data_wr;
  logic [1:0]  data_size;
  logic [31:0] data_addr;
  logic [3:0]  data_wstrb;
  logic [31:0] data_wdata;
  logic        data_addr_ok;
  logic        data_data_ok;
  logic [31:0] data_rdata;

  logic [31:0] inst_q[$];
  exp_t        data_q[$];
  logic [31:0] mem[logic [31:0]];
  logic [31:0] last_data_exp;
  int n_cmp = 0;
  int n_fail = 0;
  int cyc = 0;
  int inst_pulses = 0;
  int data_pulses = 0;
  int ar_delay, r_delay, aw_delay, w_delay, b_delay;

  cpu_sram_axi_bridge_if #(.ADDR_W(32), .DATA_W(32)) axi ();

  cpu_sram_axi_bridge #(.ADDR_W(32), .DATA_W(32)) dut (
    .clk(clk), .rst(rst),
    .inst_req(inst_req), .inst_size(inst_size), .inst_addr(inst_addr),
    .inst_addr_ok(inst_addr_ok), .inst_data_ok(inst_data_ok), .inst_rdata(inst_rdata),
    .data_req(data_req), .data_wr(data_wr), .data_size(data_size), .data_addr(data_addr),
    .data_wstrb(data_wstrb), .data_wdata(data_wdata), .data_addr_ok(data_addr_ok),
    .data_data_ok(data_data_ok), .data_rdata(data_rdata),
    .axi(axi)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("[TB] FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] mem_rd(input logic [31:0] a);
    if (mem.exists(a)) return mem[a];
    return {a[15:0], 16'hD00D};
  endfunction

  // AXI slave: each channel handshakes after its configured number of waiting cycles.
  initial begin
    int ar_wait, r_wait, aw_wait, w_wait, b_wait;
    bit rd_pend, aw_got, w_got;
    logic [31:0] rd_addr, wr_addr, wr_data, cur;
    logic [3:0] wr_strb;
    axi.arready = 0; axi.rvalid = 0; axi.rdata = 0; axi.rid = 0;
    axi.awready = 0; axi.wready = 0; axi.bvalid = 0;
    ar_wait = 0; r_wait = 0; aw_wait = 0; w_wait = 0; b_wait = 0;
    rd_pend = 0; aw_got = 0; w_got = 0;
    rd_addr = 0; wr_addr = 0; wr_data = 0; wr_strb = 0; cur = 0;
    forever begin
      @(negedge clk);
      if (rst) begin
        axi.arready = 0; axi.rvalid = 0; axi.awready = 0; axi.wready = 0; axi.bvalid = 0;
        ar_wait = 0; r_wait = 0; aw_wait = 0; w_wait = 0; b_wait = 0;
        rd_pend = 0; aw_got = 0; w_got = 0;
      end else begin
        if (axi.rvalid) begin
          axi.rvalid = 0;
          rd_pend = 0;
        end
        if (axi.arready) begin
          axi.arready = 0;
          rd_pend = 1;
          r_wait = 0;
        end else if (axi.arvalid && !rd_pend) begin
          if (ar_wait >= ar_delay) begin
            axi.arready = 1;
            rd_addr = axi.araddr;
            ar_wait = 0;
          end else ar_wait++;
        end
        if (rd_pend && !axi.rvalid) begin
          if (r_wait >= r_delay) begin
            axi.rvalid = 1;
            axi.rdata = mem_rd(rd_addr);
          end else r_wait++;
        end
        if (axi.bvalid) axi.bvalid = 0;
        if (axi.awready) begin
          axi.awready = 0;
          aw_got = 1;
        end else if (axi.awvalid && !aw_got) begin
          if (aw_wait >= aw_delay) begin
            axi.awready = 1;
            wr_addr = axi.awaddr;
            aw_wait = 0;
          end else aw_wait++;
        end
        if (axi.wready) begin
          axi.wready = 0;
          w_got = 1;
        end else if (axi.wvalid && !w_got) begin
          if (w_wait >= w_delay) begin
            axi.wready = 1;
            wr_data = axi.wdata;
            wr_strb = axi.wstrb;
            w_wait = 0;
          end else w_wait++;
        end
        if (aw_got && w_got && !axi.bvalid) begin
          if (b_wait >= b_delay) begin
            cur = mem_rd(wr_addr);
            for (int b = 0; b < 4; b++) if (wr_strb[b]) cur[8*b +: 8] = wr_data[8*b +: 8];
            mem[wr_addr] = cur;
            axi.bvalid = 1;
            aw_got = 0;
            w_got = 0;
            b_wait = 0;
          end else b_wait++;
        end
      end
    end
  end

  // Scoreboard: every data_ok pulse must match the oldest expectation of its port.
  initial forever begin
    exp_t e;
    @(negedge clk);
    if (!rst) begin
      if (inst_data_ok) begin
        inst_pulses++;
        checkOutput("inst_ok_expected", 32'(inst_q.size() != 0), 32'd1);
        if (inst_q.size() != 0) checkOutput("inst_rdata", inst_rdata, inst_q.pop_front());
      end
      if (data_data_ok) begin
        data_pulses++;
        checkOutput("data_ok_expected", 32'(data_q.size() != 0), 32'd1);
        if (data_q.size() != 0) begin
          e = data_q.pop_front();
          if (e.wr) checkOutput("data_rdata_hold", data_rdata, last_data_exp);
          else begin
            checkOutput("data_rdata", data_rdata, e.data);
            last_data_exp = e.data;
          end
        end
      end
    end
  end

  task automatic applyStimulus(input bit is_data, input bit wr, input logic [31:0] addr,
                               input logic [1:0] size, input logic [3:0] strb,
                               input logic [31:0] wd, input logic [31:0] exp, output int acc);
    bit got = 0;
    exp_t e;
    acc = -1;
    if (is_data) begin
      data_req = 1; data_wr = wr; data_addr = addr; data_size = size;
      data_wstrb = strb; data_wdata = wd;
    end else begin
      inst_req = 1; inst_addr = addr; inst_size = size;
    end
    for (int i = 0; i < 60 && !got; i++) begin
      #1;
      if (is_data ? data_addr_ok : inst_addr_ok) begin
        got = 1;
        acc = cyc;
        @(posedge clk);
        if (is_data) begin
          e.wr = wr;
          e.data = exp;
          data_q.push_back(e);
        end else inst_q.push_back(exp);
      end
      @(negedge clk);
    end
    if (is_data) data_req = 0; else inst_req = 0;
    checkOutput(is_data ? "data_accept" : "inst_accept", 32'(got), 32'd1);
  endtask

  task automatic waitDrain(input int max);
    for (int i = 0; i < max && (inst_q.size() != 0 || data_q.size() != 0); i++) @(negedge clk);
    #1;
    checkOutput("drain", 32'(inst_q.size() + data_q.size()), 32'd0);
  endtask

  initial begin
    exp_t e;
    int acc_a, acc_b, acc_w, acc_i, b_cyc, awc, wc, p0;
    bit got, prev_b;
    inst_req = 0; inst_size = 0; inst_addr = 0;
    data_req = 0; data_wr = 0; data_size = 0; data_addr = 0; data_wstrb = 0; data_wdata = 0;
    ar_delay = 0; r_delay = 0; aw_delay = 0; w_delay = 0; b_delay = 0;
    last_data_exp = 0;
    mem[32'h1C00_0000] = 32'h0280_0C0C;
    rst = 1;
    repeat (3) @(negedge clk);
    #1;
    checkOutput("rst_arvalid", 32'(axi.arvalid), 0);
    checkOutput("rst_rready", 32'(axi.rready), 0);
    checkOutput("rst_awvalid", 32'(axi.awvalid), 0);
    checkOutput("rst_wvalid", 32'(axi.wvalid), 0);
    checkOutput("rst_bready", 32'(axi.bready), 0);
    checkOutput("rst_inst_ok", 32'(inst_data_ok), 0);
    checkOutput("rst_data_ok", 32'(data_data_ok), 0);
    checkOutput("rst_inst_rdata", inst_rdata, 0);
    checkOutput("rst_data_rdata", data_rdata, 0);
    checkOutput("rst_araddr", axi.araddr, 0);
    checkOutput("rst_awaddr", axi.awaddr, 0);
    rst = 0;
    @(negedge clk);

    $display("[TB] step 1: single fetch with minimum latency");
    inst_req = 1; inst_addr = 32'h1C00_0000; inst_size = 2;
    #1 checkOutput("s1_addr_ok", 32'(inst_addr_ok), 1);
    @(posedge clk) inst_q.push_back(32'h0280_0C0C);
    @(negedge clk) inst_req = 0;
    #1;
    checkOutput("s1_arvalid", 32'(axi.arvalid), 1);
    checkOutput("s1_arid", 32'(axi.arid), 0);
    checkOutput("s1_arsize", 32'(axi.arsize), 2);
    checkOutput("s1_araddr", axi.araddr, 32'h1C00_0000);
    @(negedge clk) #1;
    checkOutput("s1_rready", 32'(axi.rready), 1);
    checkOutput("s1_ok_early", 32'(inst_data_ok), 0);
    @(negedge clk) #1;
    checkOutput("s1_ok_t3", 32'(inst_data_ok), 1);
    checkOutput("s1_rdata_t3", inst_rdata, 32'h0280_0C0C);
    waitDrain(10);

    $display("[TB] step 2: simultaneous fetch and load, data wins");
    @(negedge clk);
    inst_req = 1; inst_addr = 32'h1C00_0004; inst_size = 2;
    data_req = 1; data_wr = 0; data_addr = 32'h0000_1000; data_size = 2;
    #1;
    checkOutput("s2_data_addr_ok", 32'(data_addr_ok), 1);
    checkOutput("s2_inst_addr_ok", 32'(inst_addr_ok), 0);
    @(posedge clk);
    e.wr = 0; e.data = 32'h1000_D00D;
    data_q.push_back(e);
    @(negedge clk) data_req = 0;
    #1;
    checkOutput("s2_arid", 32'(axi.arid), 1);
    checkOutput("s2_araddr", axi.araddr, 32'h0000_1000);
    got = 0;
    for (int i = 0; i < 20 && !got; i++) begin
      if (inst_addr_ok) begin
        got = 1;
        checkOutput("s2_inst_after_load", 32'(data_data_ok), 1);
        @(posedge clk) inst_q.push_back(32'h0004_D00D);
        @(negedge clk) inst_req = 0;
      end else begin
        @(negedge clk);
        #1;
      end
    end
    inst_req = 0;
    checkOutput("s2_inst_accept", 32'(got), 1);
    waitDrain(20);

    $display("[TB] step 3: store with delayed awready");
    aw_delay = 2; w_delay = 0; b_delay = 1;
    @(negedge clk);
    p0 = data_pulses;
    applyStimulus(1, 1, 32'h10, 2'd1, 4'h3, 32'h0000_BEEF, 0, acc_w);
    awc = 0; wc = 0;
    for (int i = 0; i < 8; i++) begin
      #1;
      if (axi.awvalid) awc++;
      if (axi.wvalid) wc++;
      if (i == 0) begin
        checkOutput("s3_awaddr", axi.awaddr, 32'h10);
        checkOutput("s3_awsize", 32'(axi.awsize), 1);
        checkOutput("s3_wstrb", 32'(axi.wstrb), 32'h3);
        checkOutput("s3_wdata", axi.wdata, 32'h0000_BEEF);
      end
      @(negedge clk);
    end
    checkOutput("s3_awvalid_cycles", 32'(awc), 3);
    checkOutput("s3_wvalid_cycles", 32'(wc), 1);
    waitDrain(20);
    repeat (3) @(negedge clk);
    checkOutput("s3_write_pulses", 32'(data_pulses - p0), 1);

    $display("[TB] step 4: load behind pending store, fetch overlaps the store");
    aw_delay = 1; w_delay = 1; b_delay = 4;
    b_cyc = 0; acc_i = -1;
    fork
      begin
        applyStimulus(1, 1, 32'h10, 2'd2, 4'hC, 32'hCAFE_0000, 0, acc_w);
        data_req = 1; data_wr = 0; data_addr = 32'h10; data_size = 2;
        got = 0; prev_b = 0;
        for (int i = 0; i < 40 && !got; i++) begin
          #1;
          if (data_addr_ok) begin
            got = 1;
            checkOutput("s4_load_after_b", 32'(prev_b), 1);
            @(posedge clk);
            e.wr = 0; e.data = 32'hCAFE_BEEF;
            data_q.push_back(e);
            @(negedge clk) data_req = 0;
          end else begin
            prev_b = axi.bvalid;
            if (axi.bvalid) b_cyc = cyc;
            @(negedge clk);
          end
        end
        data_req = 0;
        checkOutput("s4_load_accept", 32'(got), 1);
      end
      begin
        @(negedge clk);
        applyStimulus(0, 0, 32'h1C00_0008, 2'd2, 4'h0, 0, 32'h0008_D00D, acc_i);
      end
    join
    checkOutput("s4_fetch_during_store", 32'(acc_i >= 0 && acc_i < b_cyc), 1);
    waitDrain(40);

    $display("[TB] step 5: back-to-back fetches with slow rvalid");
    r_delay = 5; aw_delay = 0; w_delay = 0; b_delay = 0;
    @(negedge clk);
    p0 = inst_pulses;
    applyStimulus(0, 0, 32'h1C00_0010, 2'd2, 4'h0, 0, 32'h0010_D00D, acc_a);
    applyStimulus(0, 0, 32'h1C00_0014, 2'd2, 4'h0, 0, 32'h0014_D00D, acc_b);
    checkOutput("s5_second_accept_gap", 32'(acc_b - acc_a), 8);
    waitDrain(40);
    repeat (3) @(negedge clk);
    checkOutput("s5_pulse_count", 32'(inst_pulses - p0), 2);

    $display("[TB] step 6: reset while waiting for rvalid");
    r_delay = 10;
    @(negedge clk);
    inst_req = 1; inst_addr = 32'h1C00_0018; inst_size = 2;
    #1 checkOutput("s6_addr_ok", 32'(inst_addr_ok), 1);
    @(posedge clk);
    @(negedge clk) inst_req = 0;
    repeat (3) @(negedge clk);
    #1 checkOutput("s6_in_r", 32'(axi.rready), 1);
    p0 = inst_pulses;
    rst = 1;
    @(negedge clk) #1;
    checkOutput("s6_arvalid", 32'(axi.arvalid), 0);
    checkOutput("s6_rready", 32'(axi.rready), 0);
    checkOutput("s6_inst_rdata", inst_rdata, 0);
    checkOutput("s6_data_rdata", data_rdata, 0);
    rst = 0;
    last_data_exp = 0;
    repeat (15) @(negedge clk);
    checkOutput("s6_no_pulse", 32'(inst_pulses - p0), 0);
    r_delay = 0;
    applyStimulus(0, 0, 32'h1C00_0000, 2'd2, 4'h0, 0, 32'h0280_0C0C, acc_a);
    waitDrain(20);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
